// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: single-port frame-buffer SRAM arbiter/sequencer.
// Reads (VGA fetch) win, but writes get a turn after STARVE_MAX reads.
// Ports: Clk/Reset_N; rd_req/rd_addr -> rd_ack/rd_data/rd_valid;
//   wr_req/wr_addr/wr_data -> wr_ack/wr_done; SRAM_ADDRESS,
//   DATA_to_SRAM, DATA_from_SRAM, SRAM_OE_N, SRAM_WE_N, bus_drive.
module sram_access_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_done,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic [DATA_W-1:0] DATA_to_SRAM,
  input  logic [DATA_W-1:0] DATA_from_SRAM,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              bus_drive
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ?
                         $clog2(ACCESS_CYCLES) : 1;
  localparam int STK_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] streak;

  logic grant_wr;
  logic grant_rd;

  assign grant_wr = wr_req && (streak == STK_MAX || !rd_req);
  assign grant_rd = !grant_wr && rd_req;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state        <= IDLE;
      cnt          <= '0;
      streak       <= '0;
      rd_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      wr_ack       <= 1'b0;
      wr_done      <= 1'b0;
      SRAM_ADDRESS <= '0;
      DATA_to_SRAM <= '0;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      bus_drive    <= 1'b0;
    end else begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      wr_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_wr: begin
              state        <= WR_SETUP;
              SRAM_ADDRESS <= wr_addr;
              DATA_to_SRAM <= wr_data;
              wr_ack       <= 1'b1;
              bus_drive    <= 1'b1;
              streak       <= '0;
            end
            grant_rd: begin
              state        <= RD;
              SRAM_ADDRESS <= rd_addr;
              rd_ack       <= 1'b1;
              SRAM_OE_N    <= 1'b0;
              cnt          <= CNT_LOAD;
              if (!wr_req)
                streak <= '0;
              else if (streak != STK_MAX)
                streak <= streak + 1'b1;
            end
            default: begin
              if (!wr_req)
                streak <= '0;
            end
          endcase
        end
        RD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            SRAM_OE_N <= 1'b1;
            rd_data   <= DATA_from_SRAM;
            rd_valid  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_SETUP: begin
          state     <= WR_STROBE;
          SRAM_WE_N <= 1'b0;
          cnt       <= CNT_LOAD;
        end
        WR_STROBE: begin
          if (cnt == '0) begin
            state     <= WR_HOLD;
            SRAM_WE_N <= 1'b1;
            wr_done   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          state     <= IDLE;
          bus_drive <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          bus_drive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: scoreboard bench for sram_access_arbiter.
// Small SRAM model on the low address byte; ACCESS_CYCLES=2, STARVE_MAX=3.
module tb_sram_access_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int AC = 2;
  localparam int SM = 3;

  logic          Clk;
  logic          Reset_N;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_done;
  logic [AW-1:0] SRAM_ADDRESS;
  logic [DW-1:0] DATA_to_SRAM;
  logic [DW-1:0] DATA_from_SRAM;
  logic          SRAM_OE_N;
  logic          SRAM_WE_N;
  logic          bus_drive;

  sram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .ACCESS_CYCLES(AC), .STARVE_MAX(SM)
  ) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_done(wr_done),
    .SRAM_ADDRESS(SRAM_ADDRESS), .DATA_to_SRAM(DATA_to_SRAM),
    .DATA_from_SRAM(DATA_from_SRAM),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .bus_drive(bus_drive)
  );

  logic [DW-1:0] mem [0:255];

  assign DATA_from_SRAM = SRAM_OE_N ? '0 : mem[SRAM_ADDRESS[7:0]];

  always @(posedge SRAM_WE_N)
    if (Reset_N === 1'b1)
      mem[SRAM_ADDRESS[7:0]] = DATA_to_SRAM;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total;
  int passed;
  logic [DW-1:0] exp_rd[$];
  byte           exp_g[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pop_rd(input string nm);
    logic [DW-1:0] e;
    total++;
    if (exp_rd.size() == 0) begin
      $display("FAIL %s: rd_valid with no expected read, got %h",
               nm, rd_data);
    end else begin
      e = exp_rd.pop_front();
      if (rd_data !== e)
        $display("FAIL %s: rd_data got %h want %h", nm, rd_data, e);
      else
        passed++;
    end
  endtask

  task automatic test_reset();
    Reset_N = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) tick();
    total++;
    if ({SRAM_OE_N, SRAM_WE_N, bus_drive} !== 3'b110)
      $display("FAIL reset_strobes: got %b want 110",
               {SRAM_OE_N, SRAM_WE_N, bus_drive});
    else passed++;
    total++;
    if ({SRAM_ADDRESS, DATA_to_SRAM, rd_data} !== '0)
      $display("FAIL reset_regs: addr %h data %h rd_data %h want 0",
               SRAM_ADDRESS, DATA_to_SRAM, rd_data);
    else passed++;
    Reset_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({rd_ack, rd_valid, wr_ack, wr_done} !== 4'b0000)
        $display("FAIL reset_pulses: cycle %0d got %b want 0000",
                 i, {rd_ack, rd_valid, wr_ack, wr_done});
      else passed++;
    end
  endtask

  task automatic test_read();
    logic [4:0] oe, we, bd, ak, vl;
    oe = '0; we = '0; bd = '0; ak = '0; vl = '0;
    mem[8'h45] = 16'hBEEF;
    exp_rd.push_back(16'hBEEF);
    rd_addr = 20'h12345;
    rd_req  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      oe = {SRAM_OE_N, oe[4:1]};
      we = {SRAM_WE_N, we[4:1]};
      bd = {bus_drive, bd[4:1]};
      ak = {rd_ack, ak[4:1]};
      vl = {rd_valid, vl[4:1]};
      if (c == 1) begin
        total++;
        if (SRAM_ADDRESS !== 20'h12345)
          $display("FAIL read_addr: got %h want 12345", SRAM_ADDRESS);
        else passed++;
        rd_req  = 1'b0;
        rd_addr = 20'h0FFFF;
      end
      if (rd_valid) pop_rd("read_data");
    end
    total++;
    if (ak !== 5'b00010)
      $display("FAIL read_ack: got %b want 00010", ak);
    else passed++;
    total++;
    if (oe !== 5'b11001)
      $display("FAIL read_oe: got %b want 11001", oe);
    else passed++;
    total++;
    if (vl !== 5'b01000)
      $display("FAIL read_valid: got %b want 01000", vl);
    else passed++;
    total++;
    if ({we, bd} !== {5'b11111, 5'b00000})
      $display("FAIL read_we_bd: we %b bd %b want 11111 00000", we, bd);
    else passed++;
  endtask

  task automatic test_write();
    logic [6:0] we, bd, ak, dn;
    we = '0; bd = '0; ak = '0; dn = '0;
    wr_addr = 20'h00010;
    wr_data = 16'hA5A5;
    wr_req  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      we = {SRAM_WE_N, we[6:1]};
      bd = {bus_drive, bd[6:1]};
      ak = {wr_ack, ak[6:1]};
      dn = {wr_done, dn[6:1]};
      if (c == 1) begin
        wr_req  = 1'b0;
        wr_addr = 20'h000FF;
        wr_data = 16'h0000;
      end
      if (c == 4) begin
        total++;
        if ({SRAM_ADDRESS, DATA_to_SRAM} !== {20'h00010, 16'hA5A5})
          $display("FAIL write_hold: addr %h data %h want 00010 a5a5",
                   SRAM_ADDRESS, DATA_to_SRAM);
        else passed++;
      end
    end
    total++;
    if (ak !== 7'b0000010)
      $display("FAIL write_ack: got %b want 0000010", ak);
    else passed++;
    total++;
    if (we !== 7'b1110011)
      $display("FAIL write_we: got %b want 1110011", we);
    else passed++;
    total++;
    if (bd !== 7'b0011110)
      $display("FAIL write_bd: got %b want 0011110", bd);
    else passed++;
    total++;
    if (dn !== 7'b0010000)
      $display("FAIL write_done: got %b want 0010000", dn);
    else passed++;
    total++;
    if (mem[8'h10] !== 16'hA5A5)
      $display("FAIL write_mem: got %h want a5a5", mem[8'h10]);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int ra, rv, wa, wd;
    ra = -1; rv = -1; wa = -1; wd = -1;
    mem[8'h22] = 16'h1234;
    exp_rd.push_back(16'h1234);
    rd_addr = 20'h00022;
    wr_addr = 20'h00033;
    wr_data = 16'h5A5A;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rd_ack) begin ra = c; rd_req = 1'b0; end
      if (wr_ack) begin wa = c; wr_req = 1'b0; end
      if (wr_done) wd = c;
      if (rd_valid) begin rv = c; pop_rd("simul_data"); end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    total++;
    if ({ra, rv} !== {32'sd1, 32'sd3})
      $display("FAIL simul_read: ack %0d valid %0d want 1 3", ra, rv);
    else passed++;
    total++;
    if ({wa, wd} !== {32'sd4, 32'sd7})
      $display("FAIL simul_write: ack %0d done %0d want 4 7", wa, wd);
    else passed++;
    total++;
    if (mem[8'h33] !== 16'h5A5A)
      $display("FAIL simul_mem: got %h want 5a5a", mem[8'h33]);
    else passed++;
  endtask

  task automatic test_starvation();
    string seq;
    int    n;
    int    viol;
    byte   g, e;
    seq = "RRRWRRRW";
    for (int i = 0; i < seq.len(); i++) exp_g.push_back(seq[i]);
    n = 0;
    viol = 0;
    rd_addr = 20'h00045;
    wr_addr = 20'h00077;
    wr_data = 16'h7777;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick();
      if (!SRAM_OE_N && (!SRAM_WE_N || bus_drive)) viol++;
      if (rd_ack || wr_ack) begin
        g = rd_ack ? "R" : "W";
        e = exp_g.pop_front();
        total++;
        if (g !== e || (rd_ack && wr_ack))
          $display("FAIL starve_grant%0d: got %s want %s", n, g, e);
        else passed++;
        n++;
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    if (n < 8) begin
      total++;
      $display("FAIL starve_timeout: got %0d grants want 8", n);
    end
    exp_g.delete();
    repeat (6) begin
      tick();
      if (!SRAM_OE_N && (!SRAM_WE_N || bus_drive)) viol++;
    end
    total++;
    if (viol !== 0)
      $display("FAIL starve_exclusion: got %0d violations want 0", viol);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int dn, ra, rv;
    wr_addr = 20'h00050;
    wr_data = 16'h1111;
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    tick();
    tick();
    total++;
    if (SRAM_WE_N !== 1'b0)
      $display("FAIL abort_pre: WE_N got %b want 0", SRAM_WE_N);
    else passed++;
    #2;
    Reset_N = 1'b0;
    #1;
    total++;
    if ({SRAM_WE_N, bus_drive, SRAM_OE_N} !== 3'b101)
      $display("FAIL abort_async: we/bd/oe got %b want 101",
               {SRAM_WE_N, bus_drive, SRAM_OE_N});
    else passed++;
    dn = 0;
    repeat (2) begin
      tick();
      if (wr_done) dn++;
    end
    Reset_N = 1'b1;
    repeat (6) begin
      tick();
      if (wr_done) dn++;
    end
    total++;
    if (dn !== 0)
      $display("FAIL abort_no_done: got %0d wr_done want 0", dn);
    else passed++;
    mem[8'h60] = 16'hCAFE;
    exp_rd.push_back(16'hCAFE);
    rd_addr = 20'h00060;
    rd_req  = 1'b1;
    ra = -1;
    rv = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rd_ack) begin ra = c; rd_req = 1'b0; end
      if (rd_valid) begin rv = c; pop_rd("abort_read_data"); end
    end
    rd_req = 1'b0;
    total++;
    if ({ra, rv} !== {32'sd1, 32'sd3})
      $display("FAIL abort_read: ack %0d valid %0d want 1 3", ra, rv);
    else passed++;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    Reset_N = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_abort();
    total++;
    if (exp_rd.size() != 0)
      $display("FAIL rd_scoreboard: %0d reads never returned",
               exp_rd.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Single-port arbiter and access sequencer for the shared 16-bit frame-buffer SRAM. It sits between two requesters and the SRAM pins plus data tristate:
- the VGA fetch path (reads, high priority);
- the next-frame controller (writes).

It grants one access at a time, generates the address, OE_N, WE_N and bus-drive timing for each access, and enforces a starvation bound so that writes always progress during active display.

## Interface

Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 2, cycles a strobe (OE_N or WE_N) stays low; minimum 1
- STARVE_MAX, 4, consecutive read grants allowed while a write is pending; minimum 1

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  system clock; all logic on rising edge
- Reset_N  in  1  asynchronous active-low reset
- rd_req  in  1  read request, level; held until rd_ack
- rd_addr  in  ADDR_W  read address, valid while rd_req
- rd_ack  out  1  one-cycle pulse: read accepted
- rd_data  out  DATA_W  read data, valid while rd_valid is high
- rd_valid  out  1  one-cycle pulse: rd_data valid
- wr_req  in  1  write request, level; held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write accepted
- wr_done  out  1  one-cycle pulse: write strobe complete
- SRAM_ADDRESS  out  ADDR_W  registered address to SRAM
- DATA_to_SRAM  out  DATA_W  registered write data to tristate
- DATA_from_SRAM  in  DATA_W  read data from tristate
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_WE_N  out  1  write enable, active-low
- bus_drive  out  1  tristate output enable; high while the arbiter drives the data bus

## Operation

- All outputs are registered.
- Reset values: SRAM_OE_N=1, SRAM_WE_N=1, bus_drive=0, SRAM_ADDRESS=0, DATA_to_SRAM=0, rd_data=0, and all pulses 0. Reset also sets state=IDLE and streak=0.
- States: IDLE, RD (ACCESS_CYCLES cycles), WR_SETUP, WR_STROBE (ACCESS_CYCLES cycles), WR_HOLD. A down-counter times RD and WR_STROBE.
- Arbitration happens in IDLE only:
  - if wr_req and (streak==STARVE_MAX or !rd_req): grant write;
  - else if rd_req: grant read;
  - else stay in IDLE.
- streak rules:
  - increments on each read grant while wr_req is high, saturating at STARVE_MAX;
  - clears on a write grant;
  - clears in any IDLE cycle with wr_req low.
- Grant latches the address (and write data) into SRAM_ADDRESS / DATA_to_SRAM. Later changes on the request inputs have no effect.
- A granted access always completes even if its req drops.
- RD: SRAM_OE_N=0 and bus_drive=0. DATA_from_SRAM is sampled on the edge that ends the last RD cycle.
- WR_SETUP: bus_drive=1, WE_N=1.
- WR_STROBE: WE_N=0, bus_drive=1.
- WR_HOLD: WE_N=1, bus_drive=1, and the address and data are held.
- OE_N and WE_N are never low together. bus_drive is never high while OE_N=0.
- Every access ends with at least one IDLE cycle (bus turnaround).

## Timing

Grant decided at edge k (cycle k is IDLE with a request present).
- Read:
  - rd_ack=1 in cycle k+1;
  - OE_N=0 in cycles k+1 .. k+ACCESS_CYCLES;
  - rd_valid=1 with rd_data in cycle k+ACCESS_CYCLES+1, which is also IDLE;
  - a new grant is possible at the end of that cycle;
  - read period = ACCESS_CYCLES+1.
- Write:
  - wr_ack=1 in cycle k+1 (WR_SETUP);
  - WE_N=0 in cycles k+2 .. k+1+ACCESS_CYCLES;
  - WR_HOLD in cycle k+2+ACCESS_CYCLES, with wr_done=1 in that cycle;
  - then IDLE;
  - write period = ACCESS_CYCLES+3.
- A requester still holding req in the ack cycle is not re-granted, because the FSM is not in IDLE.
- Reset_N low forces OE_N, WE_N and bus_drive high/inactive immediately, with no clock edge needed, including mid-strobe. The aborted access is not acknowledged further.
- After Reset_N rises, the first grant can occur at the first edge.

## Test plan

- Reset with Reset_N=0 for 3 cycles, requests idle -> all outputs at reset values; no pulses for 5 cycles after release.
- Read, ACCESS_CYCLES=2, rd_addr=0x12345, model returns 0xBEEF -> rd_ack cycle 1; OE_N low cycles 1–2; rd_valid cycle 3 with rd_data=0xBEEF; WE_N and bus_drive stay inactive throughout.
- Write, wr_addr=0x00010, wr_data=0xA5A5 -> wr_ack cycle 1; WE_N low exactly cycles 2–3; bus_drive high cycles 1–4; wr_done cycle 4; memory[0x10]=0xA5A5.
- rd_req and wr_req rise in the same cycle -> read granted first; write granted at the IDLE following rd_valid; both complete correctly.
- STARVE_MAX=3, rd_req and wr_req held high continuously -> grant sequence R,R,R,W,R,R,R,W; no write waits more than 3 read accesses.
- Reset_N driven low during the second WE_N-low cycle -> WE_N=1 and bus_drive=0 before the next edge; no wr_done; a read after release completes normally.
